// File: rtl/servant_spi_arbiter_pkg.sv
// Shared encodings for the servant SPI memory arbiter: FSM states, owner ids
// and the fixed byte-select used for instruction fetches.
package servant_spi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic       OWNER_I  = 1'b0;
  localparam logic       OWNER_D  = 1'b1;
  localparam logic [3:0] IBUS_SEL = 4'b1111;

endpackage

// File: rtl/servant_spi_arbiter.sv
// Two-master Wishbone arbiter in front of the SPI memory bridge. It registers
// one request at a time and returns the bridge response to the granted master.
module servant_spi_arbiter
  import servant_spi_arbiter_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [AW-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  output logic [AW-1:0] o_mem_adr,
  output logic [31:0]   o_mem_dat,
  output logic [3:0]    o_mem_sel,
  output logic          o_mem_we,
  output logic          o_mem_cyc,
  input  logic [31:0]   i_mem_rdt,
  input  logic          i_mem_ack,
  output logic          o_owner,
  output logic          o_busy,
  output logic [1:0]    o_state
);

  // Handshake: a master holds cyc (with its address/data stable) until it sees
  // a one-cycle ack; the bridge likewise answers o_mem_cyc with one i_mem_ack.
  state_t state;
  logic   win;
  logic   ack_ok;

  // Round-robin: on a tie the master that did not own the last grant wins.
  function automatic logic pick_owner(input logic icyc, input logic dcyc,
                                      input logic last);
    if (icyc && dcyc) return ~last;
    else if (dcyc)    return OWNER_D;
    else              return OWNER_I;
  endfunction

  assign win = pick_owner(i_ibus_cyc, i_dbus_cyc, o_owner);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      o_mem_cyc <= 1'b0;
      o_mem_adr <= '0;
      o_mem_dat <= '0;
      o_mem_sel <= '0;
      o_mem_we  <= 1'b0;
      o_owner   <= OWNER_D;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_ibus_cyc || i_dbus_cyc) begin
            o_owner   <= win;
            o_mem_cyc <= 1'b1;
            state     <= ST_BUSY;
            if (win == OWNER_I) begin
              o_mem_adr <= i_ibus_adr;
              o_mem_dat <= '0;
              o_mem_sel <= IBUS_SEL;
              o_mem_we  <= 1'b0;
            end else begin
              o_mem_adr <= i_dbus_adr;
              o_mem_dat <= i_dbus_dat;
              o_mem_sel <= i_dbus_sel;
              o_mem_we  <= i_dbus_we;
            end
          end
        end
        ST_BUSY: begin
          if (i_mem_ack) begin
            o_mem_cyc <= 1'b0;
            o_mem_adr <= '0;
            o_mem_dat <= '0;
            o_mem_sel <= '0;
            o_mem_we  <= 1'b0;
            state     <= ST_RECOVER;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A master that dropped cyc mid-transaction gets no ack; the bridge still finishes.
  assign ack_ok     = !i_rst && (state == ST_BUSY) && i_mem_ack;
  assign o_ibus_ack = ack_ok && (o_owner == OWNER_I) && i_ibus_cyc;
  assign o_dbus_ack = ack_ok && (o_owner == OWNER_D) && i_dbus_cyc;
  assign o_ibus_rdt = i_mem_rdt;
  assign o_dbus_rdt = i_mem_rdt;
  assign o_busy     = (state == ST_BUSY);
  assign o_state    = state;

endmodule

// File: tb/tb_servant_spi_arbiter.sv
// Directed bench for servant_spi_arbiter: a table of single transactions plus
// hand-written sequences for round-robin, abort and mid-transaction reset.
module tb_servant_spi_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [31:0] o_mem_adr;
  logic [31:0] o_mem_dat;
  logic [3:0]  o_mem_sel;
  logic        o_mem_we;
  logic        o_mem_cyc;
  logic [31:0] i_mem_rdt;
  logic        i_mem_ack;
  logic        o_owner;
  logic        o_busy;
  logic [1:0]  o_state;

  servant_spi_arbiter #(.AW(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
    .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
    .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
    .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat), .o_mem_sel(o_mem_sel),
    .o_mem_we(o_mem_we), .o_mem_cyc(o_mem_cyc),
    .i_mem_rdt(i_mem_rdt), .i_mem_ack(i_mem_ack),
    .o_owner(o_owner), .o_busy(o_busy), .o_state(o_state)
  );

  // Clock and reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        icyc;
    logic [31:0] iadr;
    logic        dcyc;
    logic [31:0] dadr;
    logic [31:0] ddat;
    logic [3:0]  dsel;
    logic        dwe;
    int          lat;
    logic [31:0] rdt;
    logic        exp_owner;
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;
    logic [3:0]  exp_sel;
    logic        exp_we;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0; i_mem_ack = 1'b0;
    i_ibus_adr = '0; i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0;
    i_mem_rdt  = 32'h0BAD_F00D;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // One table entry: request from IDLE, bridge ack after lat cycles, recovery.
  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    i_ibus_cyc = v.icyc; i_ibus_adr = v.iadr;
    i_dbus_cyc = v.dcyc; i_dbus_adr = v.dadr; i_dbus_dat = v.ddat;
    i_dbus_sel = v.dsel; i_dbus_we = v.dwe;
    #1 check($sformatf("v%0d_pre_cyc", k), {31'b0, o_mem_cyc}, 32'd0);
    @(negedge i_clk);
    check($sformatf("v%0d_cyc", k), {31'b0, o_mem_cyc}, 32'd1);
    check($sformatf("v%0d_owner", k), {31'b0, o_owner}, {31'b0, v.exp_owner});
    check($sformatf("v%0d_adr", k), o_mem_adr, v.exp_adr);
    check($sformatf("v%0d_dat", k), o_mem_dat, v.exp_dat);
    check($sformatf("v%0d_sel", k), {28'b0, o_mem_sel}, {28'b0, v.exp_sel});
    check($sformatf("v%0d_we", k), {31'b0, o_mem_we}, {31'b0, v.exp_we});
    check($sformatf("v%0d_busy", k), {31'b0, o_busy}, 32'd1);
    for (int c = 1; c < v.lat; c++) begin
      @(negedge i_clk);
      i_ibus_adr = $urandom; i_dbus_adr = $urandom; i_dbus_dat = $urandom;
      #1 check($sformatf("v%0d_early_ack", k), {30'b0, o_ibus_ack, o_dbus_ack}, 32'd0);
      check($sformatf("v%0d_held_adr", k), o_mem_adr, v.exp_adr);
    end
    @(negedge i_clk);
    i_mem_ack = 1'b1; i_mem_rdt = v.rdt;
    exp_q.push_back(v.rdt);
    #1 check($sformatf("v%0d_iack", k), {31'b0, o_ibus_ack}, {31'b0, v.exp_owner == 1'b0});
    check($sformatf("v%0d_dack", k), {31'b0, o_dbus_ack}, {31'b0, v.exp_owner == 1'b1});
    check($sformatf("v%0d_rdt", k), v.exp_owner ? o_dbus_rdt : o_ibus_rdt, exp_q.pop_front());
    @(negedge i_clk);
    i_mem_ack = 1'b0; i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
    #1 check($sformatf("v%0d_rec_state", k), {30'b0, o_state}, 32'd2);
    check($sformatf("v%0d_rec_cyc", k), {31'b0, o_mem_cyc}, 32'd0);
    check($sformatf("v%0d_rec_adr", k), o_mem_adr, 32'd0);
    @(negedge i_clk);
    check($sformatf("v%0d_idle", k), {30'b0, o_state}, 32'd0);
  endtask

  initial begin
    int w;
    //            icyc iadr        dcyc dadr        ddat          dsel     dwe lat rdt           own adr         dat           sel      we
    vecs[0] = '{1'b1, 32'h100,  1'b0, 32'h7777, 32'hFFFF_FFFF, 4'b0011, 1'b1, 20, 32'hA5A5_A5A5, 1'b0, 32'h100,  32'h0,         4'b1111, 1'b0};
    vecs[1] = '{1'b0, 32'h0,    1'b1, 32'h82E0, 32'h1234_5678, 4'b0100, 1'b1, 4,  32'h0,         1'b1, 32'h82E0, 32'h1234_5678, 4'b0100, 1'b1};
    vecs[2] = '{1'b1, 32'h200,  1'b1, 32'h300,  32'hDEAD_BEEF, 4'b1000, 1'b1, 3,  32'h1111_2222, 1'b0, 32'h200,  32'h0,         4'b1111, 1'b0};
    vecs[3] = '{1'b1, 32'h204,  1'b1, 32'h304,  32'hCAFE_0001, 4'b1111, 1'b0, 2,  32'h3333_4444, 1'b1, 32'h304,  32'hCAFE_0001, 4'b1111, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFC, 1'b0, 32'h0,    32'h0,         4'b0000, 1'b0, 1,  32'h5555_6666, 1'b0, 32'hFFFC,  32'h0,        4'b1111, 1'b0};

    idle_inputs();
    do_reset();
    check("rst_cyc",   {31'b0, o_mem_cyc}, 32'd0);
    check("rst_owner", {31'b0, o_owner},   32'd1);
    check("rst_busy",  {31'b0, o_busy},    32'd0);
    check("rst_adr",   o_mem_adr,          32'd0);
    check("rst_sel",   {28'b0, o_mem_sel}, 32'd0);
    check("rst_acks",  {30'b0, o_ibus_ack, o_dbus_ack}, 32'd0);

    for (int k = 0; k < 5; k++) run_vec(k);

    // Both masters request continuously from reset: I, D, I, D with 2-cycle gaps.
    do_reset();
    i_ibus_cyc = 1'b1; i_ibus_adr = 32'h1000;
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h2000; i_dbus_dat = 32'h55AA; i_dbus_sel = 4'b0001; i_dbus_we = 1'b1;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      while (!o_mem_cyc && w < 10) begin @(negedge i_clk); w++; end
      check($sformatf("rr%0d_gap", t), w, (t == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr%0d_owner", t), {31'b0, o_owner}, {31'b0, t[0]});
      check($sformatf("rr%0d_adr", t), o_mem_adr, t[0] ? 32'h2000 : 32'h1000);
      repeat (3) @(negedge i_clk);
      i_mem_ack = 1'b1; i_mem_rdt = 32'hC0DE_0000 + t;
      #1 check($sformatf("rr%0d_acks", t), {30'b0, o_ibus_ack, o_dbus_ack}, t[0] ? 32'd1 : 32'd2);
      @(negedge i_clk);
      i_mem_ack = 1'b0;
    end
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rr_end_idle", {30'b0, o_state}, 32'd0);

    // dbus aborts 3 cycles into BUSY; ibus waits behind it.
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h600; i_dbus_we = 1'b0; i_dbus_sel = 4'b1111;
    @(negedge i_clk);
    check("ab_owner", {31'b0, o_owner}, 32'd1);
    repeat (3) @(negedge i_clk);
    i_dbus_cyc = 1'b0; i_ibus_cyc = 1'b1; i_ibus_adr = 32'h400;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      check("ab_hold_cyc", {31'b0, o_mem_cyc}, 32'd1);
    end
    i_mem_ack = 1'b1; i_mem_rdt = 32'hDEAD_0000;
    #1 check("ab_swallow", {30'b0, o_ibus_ack, o_dbus_ack}, 32'd0);
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    check("ab_recover", {30'b0, o_state}, 32'd2);
    repeat (2) @(negedge i_clk);
    check("ab_next_owner", {31'b0, o_owner}, 32'd0);
    check("ab_next_adr", o_mem_adr, 32'h400);
    @(negedge i_clk);
    i_mem_ack = 1'b1; i_mem_rdt = 32'h0000_BEEF;
    #1 check("ab_next_ack", {30'b0, o_ibus_ack, o_dbus_ack}, 32'd2);
    check("ab_next_rdt", o_ibus_rdt, 32'h0000_BEEF);
    @(negedge i_clk);
    i_mem_ack = 1'b0; i_ibus_cyc = 1'b0;
    repeat (2) @(negedge i_clk);

    // Reset in the middle of a dbus transaction, then a stray bridge ack.
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h500;
    @(negedge i_clk);
    check("mr_busy", {31'b0, o_busy}, 32'd1);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1; i_mem_ack = 1'b1;
    #1 check("mr_ack_in_rst", {30'b0, o_ibus_ack, o_dbus_ack}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0; i_dbus_cyc = 1'b0;
    #1 check("mr_cyc", {31'b0, o_mem_cyc}, 32'd0);
    check("mr_busy_low", {31'b0, o_busy}, 32'd0);
    check("mr_owner", {31'b0, o_owner}, 32'd1);
    check("mr_adr", o_mem_adr, 32'd0);
    check("mr_stray_ack", {30'b0, o_ibus_ack, o_dbus_ack}, 32'd0);
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    check("mr_still_idle", {30'b0, o_state}, 32'd0);
    check("mr_still_cyc", {31'b0, o_mem_cyc}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
